// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop sync, 3-sample majority vote, valid/ready holding register.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_os #(
  parameter int unsigned CLK_FREQUENCY = 100_000_000,
  parameter int unsigned BAUD_RATE     = 115_200,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned OVERSAMPLE    = 16,
  parameter int unsigned STOP_BITS     = 1,
  parameter int unsigned PARITY_ODD    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 received_bit,
  output logic [DATA_BITS-1:0] processed_data,
  output logic                 processed_data_valid,
  input  logic                 processed_data_ready,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 overrun_error
);
  localparam int unsigned DIV = CLK_FREQUENCY / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned TW  = $clog2(DIV);
  localparam int unsigned SW  = $clog2(OVERSAMPLE);
  localparam int unsigned BW  = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] S_A       = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_B       = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_C       = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  if (DIV < 2 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_rx_os: illegal parameter set (DIV must be >= 2)");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state_q;
  logic                 sync1_q, rx_s_q;
  logic [TW-1:0]        tick_q;
  logic [SW-1:0]        s_q;
  logic [BW-1:0]        bit_q;
  logic                 stop_idx_q;
  logic                 smp_a_q, smp_b_q;
  logic [DATA_BITS-1:0] shift_q, data_q;
  logic                 stop_bad_q;
  logic                 valid_q, fe_q, ov_q;

  logic tick_c, vote_c, vote_tick_c, bit_end_c, stop_fail_c, par_fail_c;

  assign tick_c      = (state_q != IDLE) && (tick_q == TICK_LAST);
  assign vote_tick_c = tick_c && (s_q == S_C);
  assign bit_end_c   = tick_c && (s_q == S_LAST);
  assign vote_c      = (smp_a_q & smp_b_q) | (smp_a_q & rx_s_q) | (smp_b_q & rx_s_q);
  assign stop_fail_c = stop_bad_q | ~vote_c;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, pe_q;
  assign par_fail_c   = par_bad_q;
  assign parity_error = pe_q;
`else
  assign par_fail_c   = 1'b0;
  assign parity_error = 1'b0;
`endif

  assign processed_data       = data_q;
  assign processed_data_valid = valid_q;
  assign framing_error        = fe_q;
  assign overrun_error        = ov_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      tick_q     <= '0;
      s_q        <= '0;
      bit_q      <= '0;
      stop_idx_q <= 1'b0;
      smp_a_q    <= 1'b0;
      smp_b_q    <= 1'b0;
      shift_q    <= '0;
      data_q     <= '0;
      stop_bad_q <= 1'b0;
      valid_q    <= 1'b0;
      fe_q       <= 1'b0;
      ov_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= 1'b0;
      pe_q       <= 1'b0;
`endif
    end else begin
      sync1_q <= received_bit;
      rx_s_q  <= sync1_q;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_q    <= 1'b0;
`endif
      if (valid_q && processed_data_ready) valid_q <= 1'b0;

      // Baud tick and per-bit sample position; both parked at 0 while idle.
      if (state_q == IDLE || tick_c) tick_q <= '0;
      else                           tick_q <= tick_q + TW'(1);
      if (state_q == IDLE)  s_q <= '0;
      else if (tick_c)      s_q <= (s_q == S_LAST) ? '0 : s_q + SW'(1);
      if (tick_c && s_q == S_A) smp_a_q <= rx_s_q;
      if (tick_c && s_q == S_B) smp_b_q <= rx_s_q;

      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_q    <= START;
            bit_q      <= '0;
            stop_idx_q <= 1'b0;
            stop_bad_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= 1'b0;
`endif
          end
        end
        START: begin
          if (vote_tick_c && vote_c) state_q <= IDLE;
          else if (bit_end_c)        state_q <= DATA;
        end
        DATA: begin
          if (vote_tick_c) shift_q <= {vote_c, shift_q[DATA_BITS-1:1]};
          if (bit_end_c) begin
            bit_q <= bit_q + BW'(1);
`ifdef UART_RX_PARITY_EN
            if (bit_q == BIT_LAST) state_q <= PARITY;
`else
            if (bit_q == BIT_LAST) state_q <= STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (vote_tick_c) par_bad_q <= vote_c != ((^shift_q) ^ 1'(PARITY_ODD));
          if (bit_end_c)   state_q   <= STOP;
        end
`endif
        STOP: begin
          // Leave on the last stop vote so a back-to-back start edge is not missed.
          if (vote_tick_c) begin
            if (stop_idx_q == STOP_LAST) begin
              state_q <= IDLE;
              s_q     <= '0;
              fe_q    <= stop_fail_c;
`ifdef UART_RX_PARITY_EN
              pe_q    <= par_bad_q;
`endif
              if (!stop_fail_c && !par_fail_c) begin
                if (valid_q && !processed_data_ready) begin
                  ov_q <= 1'b1;
                end else begin
                  data_q  <= shift_q;
                  valid_q <= 1'b1;
                end
              end
            end else begin
              stop_bad_q <= stop_fail_c;
            end
          end else if (bit_end_c) begin
            stop_idx_q <= stop_idx_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
